arm_multicycle_ctrl: RTL and testbench
======================================

// Module: arm_multicycle_ctrl
// PURPOSE
//  Multicycle main controller for the ARM subset datapath (ADD/SUB/AND/ORR, LDR/STR, B).
//  Sequences one shared ALU/memory port per instruction through a Moore FSM.
//  Owns the NZCV flag register and evaluates the condition field.
//  Sits between the instruction register and the datapath muxes/enables.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded on reset
// PORTS
//  clk          in   1  system clock, rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  cond         in   4  IR[31:28]; stable from DECODE to end of instruction
//  op           in   2  IR[27:26]
//  funct        in   6  IR[25:20] (I, cmd[3:0], S/L)
//  rd           in   4  IR[15:12]
//  alu_flags    in   4  {N,Z,C,V} from ALU, valid in EXECUTE states
//  mem_ready    in   1  memory completes the current access this cycle
//  pc_write     out  1  PC register enable
//  adr_src      out  1  0=PC, 1=ALU result as memory address
//  mem_write    out  1  memory write strobe, held until mem_ready
//  ir_write     out  1  IR enable
//  result_src   out  2  00=ALUOut reg, 01=ReadData reg, 10=ALU result
//  alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
//  alu_src_a    out  1  0=RD1, 1=PC
//  alu_src_b    out  2  00=RD2, 01=ExtImm, 10=const 4
//  imm_src      out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
//  reg_src      out  2  [0]=1 RA1<-R15, [1]=1 RA2<-Rd
//  reg_write    out  1  register file write enable
//  flags        out  4  current NZCV
//  illegal_op   out  1  one-cycle pulse in DECODE on unsupported encoding
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
//  Reset (async): state=FETCH, flags=RESET_FLAGS; while reset_n=0, all strobes
//   (pc_write, ir_write, mem_write, reg_write) = 0; mux selects = FETCH values.
//  FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10; waits while
//   mem_ready=0 (no strobes); on mem_ready=1 pulse ir_write+pc_write, ->DECODE.
//  DECODE: alu_src_a=1, alu_src_b=10, ADD (PC+8 for R15 reads); imm_src/reg_src
//   from op. cond_ex computed vs flags (EQ..LE per ARM, AL=1110 true):
//   cond=1111, op=11, or DP cmd not in {0100,0010,0000,1100} -> illegal_op=1, ->FETCH;
//   cond_ex=0 -> FETCH (no side effects). Else op 01 -> MEMADR; op 00 -> EXECI if
//   funct[5] else EXECR; op 10 -> BRANCH.
//  MEMADR: alu_src_a=0, alu_src_b=01, ADD; ->MEMRD if funct[0] else MEMWR.
//  MEMRD: adr_src=1; hold until mem_ready; ->MEMWB.  MEMWB: result_src=01, reg_write.
//  MEMWR: adr_src=1, mem_write=1 held until the mem_ready cycle; ->FETCH.
//  EXECR/EXECI: alu_src_a=0, alu_src_b=00/01, alu_control from cmd; if funct[0]=1
//   flags update at cycle end: N,Z always; C,V only for ADD/SUB. ->ALUWB.
//  ALUWB: result_src=00, reg_write=1; if rd=4'hF also pc_write=1. ->FETCH.
//  BRANCH: alu_src_a=0, alu_src_b=01, ADD, result_src=10, pc_write=1; ->FETCH.
//  Non-EXEC states: alu_control=ADD. MEMWB/ALUWB with rd=15 write PC, not R15.
//  Latency at mem_ready=1: DP 4, LDR 5, STR 4, B 3, cond-fail/illegal 2 cycles.
//  Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle; no other stalls.
//  Reset mid-instruction: abandons it; mem_write drops asynchronously.
// STRUCTURE
//  Package arm_ctrl_pkg: state_e enum, op codes, cond codes, DP cmd codes,
//   alu_control/result_src/alu_src_b/imm_src encodings.
//  Sub-module arm_cond_check: combinational (cond, flags) -> cond_ex.
//  Remainder: state register, next-state logic, output decode, flag register.
// TESTING
//  ADD R1,R2,R3 (cond=E,op=00,funct=001000), mem_ready=1 -> states F,D,ER,WB;
//   reg_write only in cycle 4, alu_control=00 in cycle 3; flags unchanged.
//  SUBS imm (funct=100101), alu_flags=4'b0110 -> flags=0110 after EXECI.
//  ANDS with flags=0011, alu_flags=1000 -> flags=1011 (C,V kept).
//  BEQ with Z=0 -> F,D,F: no pc_write in DECODE; with Z=1 -> pc_write in BRANCH.
//  LDR (op=01,funct=011001), mem_ready low 2 cycles in MEMRD -> 7 cycles total,
//   reg_write+result_src=01 in MEMWB; STR holds mem_write=1 until mem_ready.
//  op=11 -> illegal_op pulse, back to FETCH; reset_n=0 in MEMWR -> mem_write=0
//   at once, state FETCH, flags=RESET_FLAGS.

Source files
------------

// File: rtl/arm_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// Latency: none (declarations only); backpressure: n/a.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_e;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
   localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10;
   localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
   localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic [1:0] result_src;
      logic [1:0] alu_control;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
   } ctrl_t;

   function automatic logic cmd_legal(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) || (cmd == CMD_ORR);
   endfunction

   function automatic logic [1:0] alu_ctl_of(input logic [3:0] cmd);
      case (cmd)
         CMD_SUB: return ALU_SUB;
         CMD_AND: return ALU_AND;
         CMD_ORR: return ALU_ORR;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in, mux selects and enables out.
// Latency: none (wiring only); backpressure: mem_ready stalls the controller.
interface arm_multicycle_ctrl_if;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_control;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] imm_src;
   logic [1:0] reg_src;
   logic       reg_write;
   logic [3:0] flags;
   logic       illegal_op;

   modport master (
      input  cond, op, funct, rd, alu_flags, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
             alu_src_a, alu_src_b, imm_src, reg_src, reg_write, flags, illegal_op
   );

   modport slave (
      output cond, op, funct, rd, alu_flags, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, result_src, alu_control,
             alu_src_a, alu_src_b, imm_src, reg_src, reg_write, flags, illegal_op
   );
endinterface

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// ARM condition-field evaluator against the current NZCV flags.
// Latency: combinational; backpressure: none.
module arm_cond_check
   import arm_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);
   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = !z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = !c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = !n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = !v;
         COND_HI: cond_ex = c && !z;
         COND_LS: cond_ex = !c || z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = !z && (n == v);
         COND_LE: cond_ex = z || (n != v);
         COND_AL: cond_ex = 1'b1;
         COND_NV: cond_ex = 1'b0;
      endcase
   end
endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle Moore controller for ADD/SUB/AND/ORR, LDR/STR, B; owns NZCV.
// Latency: DP 4, LDR 5, STR 4, B 3, skipped 2 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
module arm_multicycle_ctrl
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   arm_multicycle_ctrl_if.master bus
);
   state_e     state, nxt;
   ctrl_t      ctrl_q;
   logic [3:0] flags_q;
   logic [3:0] cmd;
   logic       cond_ex, illegal, fetch_go, sets_cv;

   assign cmd     = bus.funct[4:1];
   assign sets_cv = (cmd == CMD_ADD) || (cmd == CMD_SUB);

   arm_cond_check u_cond (
      .cond    (bus.cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Selects/enables for a given state; registered on entry so outputs come straight from flops.
   // A write-back to rd=15 goes to the PC instead of the register file.
   function automatic ctrl_t ctrl_for(input state_e s, input logic [3:0] c, input logic [3:0] dst);
      ctrl_t o;
      o             = '0;
      o.alu_control = ALU_ADD;
      o.alu_src_b   = SRCB_RD2;
      o.result_src  = RES_ALUOUT;
      case (s)
         S_FETCH, S_DECODE: begin
            o.alu_src_a  = 1'b1;
            o.alu_src_b  = SRCB_FOUR;
            o.result_src = RES_ALU;
         end
         S_MEMADR: o.alu_src_b = SRCB_IMM;
         S_MEMRD:  o.adr_src = 1'b1;
         S_MEMWB: begin
            o.result_src = RES_RDATA;
            o.pc_write   = (dst == 4'hF);
            o.reg_write  = (dst != 4'hF);
         end
         S_MEMWR: begin
            o.adr_src   = 1'b1;
            o.mem_write = 1'b1;
         end
         S_EXECR: o.alu_control = alu_ctl_of(c);
         S_EXECI: begin
            o.alu_control = alu_ctl_of(c);
            o.alu_src_b   = SRCB_IMM;
         end
         S_ALUWB: begin
            o.pc_write  = (dst == 4'hF);
            o.reg_write = (dst != 4'hF);
         end
         S_BRANCH: begin
            o.alu_src_b  = SRCB_IMM;
            o.result_src = RES_ALU;
            o.pc_write   = 1'b1;
         end
         default: ;
      endcase
      return o;
   endfunction

   always_comb begin
      nxt     = state;
      illegal = 1'b0;
      case (state)
         S_FETCH: if (bus.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            if (bus.cond == COND_NV || bus.op == OP_ILL ||
                (bus.op == OP_DP && !cmd_legal(cmd))) begin
               illegal = 1'b1;
               nxt     = S_FETCH;
            end else if (!cond_ex) begin
               nxt = S_FETCH;
            end else begin
               case (bus.op)
                  OP_MEM:  nxt = S_MEMADR;
                  OP_DP:   nxt = bus.funct[5] ? S_EXECI : S_EXECR;
                  default: nxt = S_BRANCH;
               endcase
            end
         end
         S_MEMADR: nxt = bus.funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.mem_ready) nxt = S_MEMWB;
         S_MEMWR:  if (bus.mem_ready) nxt = S_FETCH;
         S_EXECR, S_EXECI: nxt = S_ALUWB;
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_FETCH;
         ctrl_q  <= ctrl_for(S_FETCH, 4'h0, 4'h0);
         flags_q <= RESET_FLAGS;
      end else begin
         state  <= nxt;
         ctrl_q <= ctrl_for(nxt, cmd, bus.rd);
         if ((state == S_EXECR || state == S_EXECI) && bus.funct[0]) begin
            flags_q[3:2] <= bus.alu_flags[3:2];
            if (sets_cv) flags_q[1:0] <= bus.alu_flags[1:0];
         end
      end
   end

   // The fetch strobes must fire in the same cycle mem_ready arrives, so they bypass the flops.
   assign fetch_go        = (state == S_FETCH) && bus.mem_ready && reset_n;
   assign bus.ir_write    = fetch_go;
   assign bus.pc_write    = fetch_go | ctrl_q.pc_write;
   assign bus.adr_src     = ctrl_q.adr_src;
   assign bus.mem_write   = ctrl_q.mem_write;
   assign bus.result_src  = ctrl_q.result_src;
   assign bus.alu_control = ctrl_q.alu_control;
   assign bus.alu_src_a   = ctrl_q.alu_src_a;
   assign bus.alu_src_b   = ctrl_q.alu_src_b;
   assign bus.reg_write   = ctrl_q.reg_write;
   assign bus.imm_src     = (bus.op == OP_MEM) ? IMM_MEM : (bus.op == OP_BR) ? IMM_BR : IMM_DP;
   assign bus.reg_src     = {bus.op == OP_MEM, bus.op == OP_BR};
   assign bus.flags       = flags_q;
   assign bus.illegal_op  = illegal;
endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized bench for arm_multicycle_ctrl against an instruction-level reference model.
module tb_arm_multicycle_ctrl;
   localparam logic [3:0] RST_FL = 4'b1010;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   arm_multicycle_ctrl_if bus();
   arm_multicycle_ctrl #(.RESET_FLAGS(RST_FL)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   logic [3:0] flags_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ARM conditions: pairs share a base test, odd codes invert it.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] fl);
      logic n, z, cf, v, base;
      {n, z, cf, v} = fl;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
   endfunction

   function automatic logic [1:0] alu_code(input logic [3:0] cmd);
      case (cmd)
         4'h4: return 2'b00;
         4'h2: return 2'b01;
         4'h0: return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

   task automatic chk_fetch_mux(input string tag);
      chk(tag, {bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src},
               {1'b0, 1'b1, 2'b10, 2'b00, 2'b10});
   endtask

   // Entered one step after the clock edge that starts the instruction's first FETCH cycle.
   // fs = fetch stall cycles, ms = memory stall cycles, xf = alu_flags during execute.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input int fs, input int ms, input logic [3:0] xf);
      logic [3:0] cmd;
      logic ill, go, is_dp, is_ld, is_st, is_br;
      logic e_pc, e_rw, e_mw, e_adr;
      int len;
      cmd   = f[4:1];
      ill   = (c == 4'hF) || (o == 2'b11) || (o == 2'b00 && !(cmd inside {4'h4, 4'h2, 4'h0, 4'hC}));
      go    = !ill && cond_ok(c, flags_m);
      is_dp = go && o == 2'b00;
      is_ld = go && o == 2'b01 && f[0];
      is_st = go && o == 2'b01 && !f[0];
      is_br = go && o == 2'b10;
      len   = fs + 2 + (is_dp ? 2 : is_br ? 1 : is_ld ? ms + 3 : is_st ? ms + 2 : 0);
      for (int k = 0; k < len; k++) begin
         if (k < fs) bus.mem_ready = 1'b0;
         else if (k == fs) bus.mem_ready = 1'b1;
         else if ((is_ld || is_st) && k >= fs + 3) bus.mem_ready = (k == fs + 3 + ms);
         else bus.mem_ready = 1'($urandom_range(0, 1));
         bus.alu_flags = (k == fs + 2) ? xf : 4'($urandom);
         if (k == fs + 1) begin
            bus.cond = c; bus.op = o; bus.funct = f; bus.rd = r;
         end
         @(negedge clk);
         e_pc  = (k == fs) || (is_br && k == fs + 2) || ((is_dp || is_ld) && k == len - 1 && r == 4'hF);
         e_rw  = (is_dp || is_ld) && k == len - 1 && r != 4'hF;
         e_mw  = is_st && k >= fs + 3;
         e_adr = (is_ld || is_st) && k >= fs + 3 && k <= fs + 3 + ms;
         chk($sformatf("strobes k=%0d op=%0d", k, o),
             {bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal_op, bus.adr_src},
             {k == fs, e_pc, e_rw, e_mw, ill && k == fs + 1, e_adr});
         if (k == fs) chk_fetch_mux("fetch_mux");
         if (k == fs + 1) begin
            chk("decode_mux", {bus.alu_src_a, bus.alu_src_b, bus.alu_control}, {1'b1, 2'b10, 2'b00});
            chk("decode_src", {bus.imm_src, bus.reg_src},
                {(o == 2'b01) ? 2'b01 : (o == 2'b10) ? 2'b10 : 2'b00, o == 2'b01, o == 2'b10});
         end
         if (k == fs + 2) begin
            if (is_dp)
               chk("exec_mux", {bus.alu_src_a, bus.alu_src_b, bus.alu_control},
                   {1'b0, f[5] ? 2'b01 : 2'b00, alu_code(cmd)});
            else if (is_ld || is_st || is_br)
               chk("adr_mux", {bus.alu_src_a, bus.alu_src_b, bus.alu_control}, {1'b0, 2'b01, 2'b00});
            if (is_br) chk("br_result_src", bus.result_src, 2'b10);
            if (is_dp && f[0]) begin
               flags_m[3:2] = xf[3:2];
               if (cmd == 4'h4 || cmd == 4'h2) flags_m[1:0] = xf[1:0];
            end
         end
         if (k == len - 1) begin
            chk("flags", bus.flags, flags_m);
            if (is_dp) chk("dp_result_src", bus.result_src, 2'b00);
            if (is_ld) chk("ld_result_src", bus.result_src, 2'b01);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      bus.mem_ready = 1'b1;
      #1;
      chk({tag, "_strobes"}, {bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write}, 4'b0000);
      chk_fetch_mux({tag, "_mux"});
      chk({tag, "_flags"}, bus.flags, RST_FL);
   endtask

   task automatic release_reset();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      flags_m = RST_FL;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] legal [4];
      logic [1:0] o;
      logic [3:0] c, r;
      logic [5:0] f;
      int sel;
      legal = '{4'h4, 4'h2, 4'h0, 4'hC};
      bus.cond = 4'hE; bus.op = 2'b00; bus.funct = 6'b001000; bus.rd = 4'h1;
      bus.alu_flags = 4'h0; bus.mem_ready = 1'b1;
      #12;
      chk_reset_outputs("reset");
      release_reset();

      run_instr(4'hE, 2'b00, 6'b001000, 4'h1, 0, 0, 4'hF);       // ADD R1,R2,R3
      run_instr(4'hE, 2'b00, 6'b100101, 4'h2, 1, 0, 4'b0110);    // SUBS imm
      chk("subs_flags", bus.flags, 4'b0110);
      run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 0, 0, 4'b0011);    // SUBS -> 0011
      run_instr(4'hE, 2'b00, 6'b000001, 4'h3, 0, 0, 4'b1000);    // ANDS keeps C,V
      chk("ands_flags", bus.flags, 4'b1011);
      run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 0, 0, 4'h0);       // BEQ, Z=0: skipped
      run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 0, 0, 4'b0100);    // SUBS -> Z=1
      run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 2, 0, 4'h0);       // BEQ taken
      run_instr(4'hE, 2'b01, 6'b011001, 4'h4, 0, 2, 4'h0);       // LDR, 7 cycles
      run_instr(4'hE, 2'b01, 6'b011000, 4'h4, 1, 3, 4'h0);       // STR with stalls
      run_instr(4'hE, 2'b11, 6'b000000, 4'h0, 0, 0, 4'h0);       // illegal op=11
      run_instr(4'hE, 2'b00, 6'b011110, 4'h5, 0, 0, 4'h0);       // illegal DP cmd

      // Reset asserted while a store is waiting in MEMWR.
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.cond = 4'hE; bus.op = 2'b01; bus.funct = 6'b011000; bus.rd = 4'h2;
      bus.mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("memwr_before_reset", bus.mem_write, 1'b1);
      #2 reset_n = 1'b0;
      #1 chk("memwr_async_drop", bus.mem_write, 1'b0);
      chk_reset_outputs("midreset");
      release_reset();
      run_instr(4'hE, 2'b00, 6'b111000, 4'h6, 0, 0, 4'h0);       // ORR imm after reset

      for (int i = 0; i < 200; i++) begin
         sel = $urandom_range(0, 19);
         o = (sel < 9) ? 2'b00 : (sel < 14) ? 2'b01 : (sel < 18) ? 2'b10 : 2'b11;
         c = $urandom_range(0, 1) ? 4'hE : 4'($urandom_range(0, 15));
         f = 6'($urandom);
         if (o == 2'b00 && $urandom_range(0, 9) != 0) f[4:1] = legal[$urandom_range(0, 3)];
         r = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         run_instr(c, o, f, r, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
